// File: rtl/aes_ct_display_if.sv
// ---------------------------------------------------------------------------
// aes_ct_display_if
// Purpose : valid/ready ciphertext handshake between the AES core and the
//           Basys3 display stage.
// Signals : ct_valid  upstream has a 128-bit ciphertext on ct_data
//           ct_data   ciphertext, word p = ct_data[16p+15:16p]
//           ct_ready  display stage accepts ct_data this cycle
// Modports: master = ciphertext producer, slave = display stage
// ---------------------------------------------------------------------------
interface aes_ct_display_if;
  logic         ct_valid;
  logic [127:0] ct_data;
  logic         ct_ready;

  modport master (output ct_valid, output ct_data, input ct_ready);
  modport slave  (input ct_valid, input ct_data, output ct_ready);
endinterface

// File: rtl/aes_ct_display.sv
// ---------------------------------------------------------------------------
// aes_ct_display
// Purpose : captures one 128-bit ciphertext and pages through it as eight
//           16-bit words on the 16 LEDs and the 4-digit multiplexed 7-seg
//           display (hex). A new ciphertext is only accepted once the
//           current one has been shown completely (one full 7->0 wrap).
// Ports   : clk       system clock (100 MHz)
//           rst_n     asynchronous reset, active-low
//           bus       aes_ct_display_if.slave (ct_valid, ct_data, ct_ready)
//           led[15:0] current page word
//           page[2:0] current page index 0..7
//           seg[6:0]  segments, active-low, {g,f,e,d,c,b,a}
//           an[3:0]   digit anodes, active-low, an[0] = rightmost digit
//           dp        decimal point, active-low
// Params  : PAGE_TICKS  clk cycles per page (min 2)
//           SCAN_TICKS  clk cycles per digit scan step (min 1)
// Option  : AES_CT_DISPLAY_NEWFLAG_EN - when defined, the rightmost decimal
//           point lights while digit 0 is active during the first pass over
//           freshly captured data. Undefined: dp is constant 1.
// ---------------------------------------------------------------------------
module aes_ct_display #(
  parameter int PAGE_TICKS = 50_000_000,
  parameter int SCAN_TICKS = 100_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_ct_display_if.slave      bus,
  output logic [15:0]          led,
  output logic [2:0]           page,
  output logic [6:0]           seg,
  output logic [3:0]           an,
  output logic                 dp
);

  localparam int PW = (PAGE_TICKS > 2) ? $clog2(PAGE_TICKS) : 1;
  localparam int SW = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [PW-1:0] PAGE_LAST = PW'(PAGE_TICKS - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_TICKS - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t          state, state_nxt;
  logic [127:0]    data, data_nxt;
  logic [PW-1:0]   page_tmr, page_tmr_nxt;
  logic [2:0]      page_nxt;
  logic [SW-1:0]   scan_tmr, scan_tmr_nxt;
  logic [1:0]      digit, digit_nxt;
  logic            pass_done, pass_done_nxt;

  logic            capture;
  logic [15:0]     word_nxt;
  logic [3:0]      nibble_nxt;
  logic [15:0]     led_nxt;
  logic [6:0]      seg_nxt;
  logic [3:0]      an_nxt;
  logic            dp_nxt;
  logic            ready_nxt;

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Next-state and next-output logic. Outputs are computed from the
  // next-state values so the registered outputs always describe the state
  // the block is in after the edge (e.g. the first word appears the cycle
  // right after capture). A capture overrides any page/scan tick.
  always_comb begin
    state_nxt     = state;
    data_nxt      = data;
    page_tmr_nxt  = page_tmr;
    page_nxt      = page;
    scan_tmr_nxt  = scan_tmr;
    digit_nxt     = digit;
    pass_done_nxt = pass_done;
    capture       = bus.ct_valid && bus.ct_ready;

    if (capture) begin
      state_nxt     = SHOW;
      data_nxt      = bus.ct_data;
      page_tmr_nxt  = '0;
      page_nxt      = '0;
      scan_tmr_nxt  = '0;
      digit_nxt     = '0;
      pass_done_nxt = 1'b0;
    end else if (state == SHOW) begin
      if (page_tmr == PAGE_LAST) begin
        page_tmr_nxt = '0;
        page_nxt     = page + 3'd1;
        if (page == 3'd7)
          pass_done_nxt = 1'b1;
      end else begin
        page_tmr_nxt = page_tmr + PW'(1);
      end

      if (scan_tmr == SCAN_LAST) begin
        scan_tmr_nxt = '0;
        digit_nxt    = digit + 2'd1;
      end else begin
        scan_tmr_nxt = scan_tmr + SW'(1);
      end
    end

    word_nxt   = data_nxt[{page_nxt, 4'b0000} +: 16];
    nibble_nxt = word_nxt[{digit_nxt, 2'b00} +: 4];

    led_nxt   = 16'h0000;
    seg_nxt   = 7'h7F;
    an_nxt    = 4'hF;
    ready_nxt = 1'b1;
    if (state_nxt == SHOW) begin
      led_nxt   = word_nxt;
      seg_nxt   = hex7(nibble_nxt);
      an_nxt    = ~(4'b0001 << digit_nxt);
      ready_nxt = pass_done_nxt;
    end

`ifdef AES_CT_DISPLAY_NEWFLAG_EN
    dp_nxt = !((state_nxt == SHOW) && (digit_nxt == 2'd0) && !pass_done_nxt);
`else
    dp_nxt = 1'b1;
`endif
  end

  // State and output registers; everything clears as soon as rst_n falls,
  // which also discards any held ciphertext.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      data         <= '0;
      page_tmr     <= '0;
      page         <= '0;
      scan_tmr     <= '0;
      digit        <= '0;
      pass_done    <= 1'b0;
      led          <= 16'h0000;
      seg          <= 7'h7F;
      an           <= 4'hF;
      dp           <= 1'b1;
      bus.ct_ready <= 1'b1;
    end else begin
      state        <= state_nxt;
      data         <= data_nxt;
      page_tmr     <= page_tmr_nxt;
      page         <= page_nxt;
      scan_tmr     <= scan_tmr_nxt;
      digit        <= digit_nxt;
      pass_done    <= pass_done_nxt;
      led          <= led_nxt;
      seg          <= seg_nxt;
      an           <= an_nxt;
      dp           <= dp_nxt;
      bus.ct_ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_aes_ct_display.sv
// ---------------------------------------------------------------------------
// tb_aes_ct_display
// Purpose : self-checking bench for aes_ct_display with PAGE_TICKS=8 and
//           SCAN_TICKS=2. A reference model tracks "cycles since capture"
//           and derives page, digit, word, glyph, ready and dp from it with
//           plain arithmetic. Honours AES_CT_DISPLAY_NEWFLAG_EN for dp.
// ---------------------------------------------------------------------------
module tb_aes_ct_display;

  localparam int PT = 8;
  localparam int ST = 2;
  localparam int PASS_CYCLES = 8 * PT;
  localparam logic [6:0] HEX_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [127:0] KAT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] led;
  logic [2:0]  page;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit           m_idle = 1'b1;
  logic [127:0] m_ct = '0;
  int           m_t = 0;

  aes_ct_display_if bus ();

  always #5 clk = ~clk;

  aes_ct_display #(.PAGE_TICKS(PT), .SCAN_TICKS(ST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .led  (led),
    .page (page),
    .seg  (seg),
    .an   (an),
    .dp   (dp)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [127:0] data);
    bus.ct_valid = valid;
    bus.ct_data  = data;
  endtask

  function automatic logic [127:0] randCt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit modelReady();
    return m_idle || (m_t >= PASS_CYCLES);
  endfunction

  // Model view of one clock edge: capture if ready and valid, else age.
  task automatic modelEdge();
    if (modelReady() && bus.ct_valid === 1'b1) begin
      m_idle = 1'b0;
      m_ct   = bus.ct_data;
      m_t    = 0;
    end else if (!m_idle) begin
      m_t++;
    end
  endtask

  task automatic modelReset();
    m_idle = 1'b1;
    m_ct   = '0;
    m_t    = 0;
  endtask

  task automatic checkAll();
    int           pg, dg;
    logic [127:0] sh;
    logic [15:0]  word;
    logic [3:0]   nib;
    logic         exp_dp;
    if (m_idle) begin
      checkOutput("led", 32'(led), 32'h0);
      checkOutput("page", 32'(page), 32'h0);
      checkOutput("an", 32'(an), 32'hF);
      checkOutput("seg", 32'(seg), 32'h7F);
      checkOutput("dp", 32'(dp), 32'h1);
      checkOutput("ct_ready", 32'(bus.ct_ready), 32'h1);
    end else begin
      pg   = (m_t / PT) % 8;
      dg   = (m_t / ST) % 4;
      sh   = m_ct >> (16 * pg);
      word = sh[15:0];
      nib  = 4'((word >> (4 * dg)) & 16'hF);
`ifdef AES_CT_DISPLAY_NEWFLAG_EN
      exp_dp = !(dg == 0 && m_t < PASS_CYCLES);
`else
      exp_dp = 1'b1;
`endif
      checkOutput("led", 32'(led), 32'(word));
      checkOutput("page", 32'(page), 32'(pg));
      checkOutput("an", 32'(an), 32'(4'hF ^ (4'b0001 << dg)));
      checkOutput("seg", 32'(seg), 32'(HEX_TAB[nib]));
      checkOutput("dp", 32'(dp), 32'(exp_dp));
      checkOutput("ct_ready", 32'(bus.ct_ready), 32'(m_t >= PASS_CYCLES));
    end
  endtask

  // One clock: model follows the edge, outputs are sampled 1 ns later.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkAll();
    end
  endtask

  initial begin
    logic [127:0] ct2;
    applyStimulus(1'b0, '0);

    // Reset state, then idle held after release.
    #12;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
    step(4);

    // Capture the known-answer ciphertext. Digit 0 shows nibble 'A'.
    applyStimulus(1'b1, KAT);
    step(1);
    checkOutput("kat_led", 32'(led), 32'hc55a);
    checkOutput("kat_page", 32'(page), 32'h0);
    checkOutput("kat_an0", 32'(an), 32'hE);
    checkOutput("kat_seg0", 32'(seg), 32'h08);
    checkOutput("kat_ready", 32'(bus.ct_ready), 32'h0);
    applyStimulus(1'b0, randCt());
    step(2);
    checkOutput("kat_an1", 32'(an), 32'hD);
    checkOutput("kat_seg1", 32'(seg), 32'h12);

    // Held data must not follow ct_data; a valid during the pass is ignored.
    while (m_t < 20) begin
      applyStimulus(1'b0, randCt());
      step(1);
    end
    ct2 = randCt();
    applyStimulus(1'b1, ct2);
    step(5);
    applyStimulus(1'b0, randCt());
    checkOutput("ignored_led", 32'(led), 32'(KAT[16 * ((m_t / PT) % 8) +: 16]));
    while (m_t < PASS_CYCLES) step(1);
    checkOutput("wrap_led", 32'(led), 32'hc55a);
    checkOutput("wrap_page", 32'(page), 32'h0);
    checkOutput("wrap_ready", 32'(bus.ct_ready), 32'h1);
    step(3);

    // After the wrap a new ciphertext is accepted at once.
    applyStimulus(1'b1, ct2);
    step(1);
    checkOutput("second_page", 32'(page), 32'h0);
    checkOutput("second_led", 32'(led), 32'(ct2[15:0]));
    applyStimulus(1'b0, randCt());

    // Asynchronous reset in the middle of page 3.
    while (m_t < 3 * PT + 2) step(1);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
    step(3);

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom % 8) == 0, randCt());
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
